// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake plus the decoder/core side.
// master = fetch_unit, slave = memory model / core around it.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;

    logic [31:0]     o_instr;
    logic            o_instr_valid;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus4;

    logic            i_retire;
    logic            i_branch;
    logic            i_jump;
    logic            i_imm_jump;
    logic            i_zero;
    logic [XLEN-1:0] i_imm_ext;
    logic [XLEN-1:0] i_alu_result;

    logic            o_trap;
    logic [XLEN-1:0] o_trap_pc;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_instr, o_instr_valid, o_pc, o_pc_plus4,
        input  i_retire, i_branch, i_jump, i_imm_jump, i_zero, i_imm_ext, i_alu_result,
        output o_trap, o_trap_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_instr, o_instr_valid, o_pc, o_pc_plus4,
        output i_retire, i_branch, i_jump, i_imm_jump, i_zero, i_imm_ext, i_alu_result,
        input  o_trap, o_trap_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: one outstanding fetch, hold until retire,
// then redirect via branch/jal/jalr or fall through; misaligned targets trap for good.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_VALID,
        ST_TRAP
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] trap_pc_reg;
    logic [31:0]     instr_reg;
    logic            req_reg;
    logic            valid_reg;
    logic            trap_reg;

    logic [XLEN-1:0] pc_plus4_next;
    logic [XLEN-1:0] target_next;
    logic            target_misaligned;

    assign pc_plus4_next = pc_reg + PC_STEP;

    // jalr beats jal beats taken branch; bit 0 of a jalr target is always dropped.
    always_comb begin
        target_next = pc_plus4_next;
        if (bus.i_imm_jump) begin
            target_next = {bus.i_alu_result[XLEN-1:1], 1'b0};
        end else if (bus.i_jump) begin
            target_next = pc_reg + bus.i_imm_ext;
        end else if (bus.i_branch && bus.i_zero) begin
            target_next = pc_reg + bus.i_imm_ext;
        end
    end

    assign target_misaligned = |target_next[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            instr_reg   <= '0;
            req_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            trap_reg    <= 1'b0;
            trap_pc_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_reg   <= 1'b1;
                    state_reg <= ST_REQ;
                end

                // Address is pc_reg, which cannot change here, so it stays stable until gnt.
                ST_REQ: begin
                    if (bus.i_imem_gnt) begin
                        req_reg <= 1'b0;
                        if (bus.i_imem_rvalid) begin
                            instr_reg <= bus.i_imem_rdata;
                            valid_reg <= 1'b1;
                            state_reg <= ST_VALID;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus.i_imem_rvalid) begin
                        instr_reg <= bus.i_imem_rdata;
                        valid_reg <= 1'b1;
                        state_reg <= ST_VALID;
                    end
                end

                ST_VALID: begin
                    if (bus.i_retire) begin
                        valid_reg <= 1'b0;
                        if (target_misaligned) begin
                            trap_reg    <= 1'b1;
                            trap_pc_reg <= target_next;
                            state_reg   <= ST_TRAP;
                        end else begin
                            pc_reg    <= target_next;
                            req_reg   <= 1'b1;
                            state_reg <= ST_REQ;
                        end
                    end
                end

                // Only reset leaves the trap state.
                ST_TRAP: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    trap_reg  <= 1'b1;
                end

                default: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_imem_req    = req_reg;
    assign bus.o_imem_addr   = pc_reg;
    assign bus.o_instr       = instr_reg;
    assign bus.o_instr_valid = valid_reg;
    assign bus.o_pc          = pc_reg;
    assign bus.o_pc_plus4    = pc_plus4_next;
    assign bus.o_trap        = trap_reg;
    assign bus.o_trap_pc     = trap_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory model, scoreboard of expected
// instruction/PC pairs, immediate-assertion checks sampled on the falling edge.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_pc = 32'h0;
    logic [31:0] cur_instr = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctrl();
        bus.i_retire     = 1'b0;
        bus.i_branch     = 1'b0;
        bus.i_jump       = 1'b0;
        bus.i_imm_jump   = 1'b0;
        bus.i_zero       = 1'b0;
        bus.i_imm_ext    = 32'h0;
        bus.i_alu_result = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},     {31'h0, bus.o_imem_req},    32'h0);
        check({tag, "_addr"},    bus.o_imem_addr,            32'h0);
        check({tag, "_instr"},   bus.o_instr,                32'h0);
        check({tag, "_valid"},   {31'h0, bus.o_instr_valid}, 32'h0);
        check({tag, "_trap"},    {31'h0, bus.o_trap},        32'h0);
        check({tag, "_trap_pc"}, bus.o_trap_pc,              32'h0);
    endtask

    // Called on a falling edge; returns on the falling edge where o_instr_valid must be high.
    task automatic do_fetch(input logic [31:0] exp_addr, input int gnt_dly,
                            input int rv_dly, input logic [31:0] data);
        int        n;
        sb_entry_t e;
        n = 0;
        while (!bus.o_imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'h0, bus.o_imem_req}, 32'h1);
        check("req_addr", bus.o_imem_addr, exp_addr);
        for (int k = 0; k < gnt_dly; k++) begin
            bus.i_imem_gnt    = 1'b0;
            bus.i_imem_rvalid = (k == 0);
            bus.i_imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            check("stall_req",   {31'h0, bus.o_imem_req},    32'h1);
            check("stall_addr",  bus.o_imem_addr,            exp_addr);
            check("stall_valid", {31'h0, bus.o_instr_valid}, 32'h0);
        end
        bus.i_imem_gnt    = 1'b1;
        bus.i_imem_rvalid = (rv_dly == 0);
        bus.i_imem_rdata  = (rv_dly == 0) ? data : 32'hBAD0_0000;
        e.instr = data;
        e.pc    = exp_addr;
        sb.push_back(e);
        @(negedge clk);
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        for (int k = 0; k < rv_dly; k++) begin
            check("wait_req",   {31'h0, bus.o_imem_req},    32'h0);
            check("wait_valid", {31'h0, bus.o_instr_valid}, 32'h0);
            bus.i_imem_rvalid = (k == rv_dly - 1);
            bus.i_imem_rdata  = (k == rv_dly - 1) ? data : 32'hBAD0_0001;
            @(negedge clk);
        end
        bus.i_imem_rvalid = 1'b0;
        check("valid_rise", {31'h0, bus.o_instr_valid}, 32'h1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            check("instr",    bus.o_instr,    e.instr);
            check("pc",       bus.o_pc,       e.pc);
            check("pc_plus4", bus.o_pc_plus4, e.pc + 32'd4);
            cur_pc    = e.pc;
            cur_instr = e.instr;
        end
    endtask

    // Holds the instruction for `hold` cycles (with a stray rvalid), then retires it.
    task automatic do_retire(input int hold, input logic br, input logic jp, input logic ij,
                             input logic z, input logic [31:0] imm, input logic [31:0] alu,
                             input logic [31:0] exp_target, input logic exp_trap);
        for (int k = 0; k < hold; k++) begin
            bus.i_imem_rvalid = (k == 0);
            bus.i_imem_rdata  = 32'hFFFF_0000;
            @(negedge clk);
            bus.i_imem_rvalid = 1'b0;
            check("hold_valid", {31'h0, bus.o_instr_valid}, 32'h1);
            check("hold_instr", bus.o_instr, cur_instr);
            check("hold_pc",    bus.o_pc,    cur_pc);
        end
        bus.i_retire     = 1'b1;
        bus.i_branch     = br;
        bus.i_jump       = jp;
        bus.i_imm_jump   = ij;
        bus.i_zero       = z;
        bus.i_imm_ext    = imm;
        bus.i_alu_result = alu;
        @(negedge clk);
        clear_ctrl();
        check("post_retire_valid", {31'h0, bus.o_instr_valid}, 32'h0);
        if (!exp_trap) begin
            check("next_req",  {31'h0, bus.o_imem_req}, 32'h1);
            check("next_addr", bus.o_imem_addr,         exp_target);
            check("next_trap", {31'h0, bus.o_trap},     32'h0);
        end else begin
            check("trap",      {31'h0, bus.o_trap},     32'h1);
            check("trap_pc",   bus.o_trap_pc,           exp_target);
            check("trap_req",  {31'h0, bus.o_imem_req}, 32'h0);
            check("trap_hold_pc", bus.o_pc,             cur_pc);
        end
    endtask

    initial begin
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'h0;
        clear_ctrl();

        // Reset values
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_pc", bus.o_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("step: reset released, req=%0b addr=%h", bus.o_imem_req, bus.o_imem_addr);

        // Zero-wait sequential fetch 0,4,8
        do_fetch(32'h0, 0, 0, 32'h0050_0093);
        $display("step: fetch pc=%h instr=%h", bus.o_pc, bus.o_instr);
        do_retire(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 1'b0);
        do_fetch(32'h4, 0, 0, 32'h0010_0113);
        do_retire(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 1'b0);
        do_fetch(32'h8, 0, 0, 32'h0020_0193);
        $display("step: fetch pc=%h instr=%h", bus.o_pc, bus.o_instr);

        // Branches at 0x10
        do_retire(0, 0, 1, 0, 0, 32'h8, 32'h0, 32'h10, 1'b0);
        do_fetch(32'h10, 0, 0, 32'h0000_0463);
        do_retire(1, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 32'h8, 1'b0);
        $display("step: taken branch -> %h", bus.o_imem_addr);
        do_fetch(32'h8, 0, 0, 32'h0080_006F);
        do_retire(0, 0, 1, 0, 0, 32'h8, 32'h0, 32'h10, 1'b0);
        do_fetch(32'h10, 0, 0, 32'h0000_0463);
        do_retire(1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h14, 1'b0);
        $display("step: untaken branch -> %h", bus.o_imem_addr);

        // Slow memory: gnt after 3 cycles, rvalid 2 cycles after gnt
        do_fetch(32'h14, 3, 2, 32'h00C0_006F);
        $display("step: stalled fetch pc=%h instr=%h", bus.o_pc, bus.o_instr);
        do_retire(2, 0, 1, 0, 0, 32'hC, 32'h0, 32'h20, 1'b0);

        // jal / jalr priority
        do_fetch(32'h20, 0, 0, 32'h1000_006F);
        do_retire(1, 0, 1, 0, 0, 32'h100, 32'h0, 32'h120, 1'b0);
        $display("step: jal -> %h", bus.o_imem_addr);
        do_fetch(32'h120, 1, 1, 32'h0000_8067);
        do_retire(1, 0, 1, 1, 1, 32'h100, 32'h41, 32'h40, 1'b0);
        $display("step: jalr -> %h", bus.o_imem_addr);

        // PC wrap from the top of the address space
        do_fetch(32'h40, 0, 0, 32'h0000_8067);
        do_retire(0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0);
        do_fetch(32'hFFFF_FFFC, 0, 0, 32'h0000_0013);
        do_retire(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        $display("step: wrap -> %h", bus.o_imem_addr);

        // Misaligned jal target traps permanently
        do_fetch(32'h0, 0, 0, 32'h0060_006F);
        do_retire(1, 0, 1, 0, 0, 32'h6, 32'h0, 32'h6, 1'b1);
        $display("step: trap at %h", bus.o_trap_pc);
        for (int k = 0; k < 4; k++) begin
            bus.i_retire = 1'b1;
            @(negedge clk);
            check("trap_sticky",     {31'h0, bus.o_trap},        32'h1);
            check("trap_no_req",     {31'h0, bus.o_imem_req},    32'h0);
            check("trap_no_valid",   {31'h0, bus.o_instr_valid}, 32'h0);
            check("trap_pc_sticky",  bus.o_trap_pc,              32'h6);
        end
        bus.i_retire = 1'b0;

        // Reset clears the trap; then reset during WAIT drops the outstanding fetch
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("trap_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req", {31'h0, bus.o_imem_req}, 32'h1);
        bus.i_imem_gnt = 1'b1;
        @(negedge clk);
        bus.i_imem_gnt = 1'b0;
        check("in_wait_req", {31'h0, bus.o_imem_req}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("wait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_imem_rvalid = 1'b1;
        bus.i_imem_rdata  = 32'hBADB_ADBA;
        @(negedge clk);
        bus.i_imem_rvalid = 1'b0;
        check("late_rvalid_valid", {31'h0, bus.o_instr_valid}, 32'h0);
        check("late_rvalid_instr", bus.o_instr, 32'h0);
        check("restart_req",  {31'h0, bus.o_imem_req}, 32'h1);
        check("restart_addr", bus.o_imem_addr, 32'h0);
        do_fetch(32'h0, 0, 0, 32'h0050_0093);
        $display("step: refetch after reset pc=%h instr=%h", bus.o_pc, bus.o_instr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
